// File: rtl/register_file_pkg.sv
// register_file_pkg: shared constants for the MIPS register file and its bench.
//   REG_ZERO            - hardwired-zero register index ($zero)
//   DEF_N / DEF_ADDR_W  - default data and address widths
//   REG_SP / REG_RA     - well-known register indices
package register_file_pkg;
  localparam int REG_ZERO   = 0;
  localparam int DEF_N      = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_SP     = 29;
  localparam int REG_RA     = 31;
endpackage

// File: rtl/register_file_decoder.sv
// write_decoder: binary address to one-hot write strobes.
//   ena    : write enable; all strobes low when deasserted
//   addr   : target entry
//   onehot : per-entry strobe, bit 0 always low so $zero never loads
module write_decoder #(
  parameter int ADDR_W = 5
) (
  input  logic                 ena,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);
  always_comb begin
    onehot = '0;
    // addr is only looked at when ena is high, so X on an idle bus is harmless
    if (ena) onehot[addr] = 1'b1;
    onehot[0] = 1'b0;
  end
endmodule

// File: rtl/register_file_reg.sv
// nreg: N-bit register with async active-high clear and load enable.
//   clk, rst : clock, asynchronous clear
//   ena      : load d on rising clk
//   d, q     : data in / stored value
module nreg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst)      q <= '0;
    else if (ena) q <= d;
endmodule

// File: rtl/register_file.sv
// register_file: 2**ADDR_W x N MIPS GPR file, two async read ports, one write port.
//   clk, rst           : clock, asynchronous active-high clear of all entries
//   rd_addr0/rd_data0  : read port 0 (rs), combinational
//   rd_addr1/rd_data1  : read port 1 (rt), combinational
//   wr_ena/wr_addr/wr_data : write-back port, taken on rising clk
// BYPASS=1 forwards a same-cycle write to matching read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [N-1:0]      rd_data0,
  output logic [N-1:0]      rd_data1,
  input  logic              wr_ena,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]      wr_data
);
  localparam int NE = 2**ADDR_W;

  logic [NE-1:0]         we;
  logic [NE-1:0][N-1:0]  q;
  logic [1:0][ADDR_W-1:0] ra;
  logic [1:0][N-1:0]     rd;

  write_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .ena    (wr_ena),
    .addr   (wr_addr),
    .onehot (we)
  );

  // $zero has no storage
  assign q[0] = '0;

  generate
    for (genvar i = 1; i < NE; i++) begin : g_ent
      nreg #(.N(N)) u_reg (
        .clk (clk),
        .rst (rst),
        .ena (we[i]),
        .d   (wr_data),
        .q   (q[i])
      );
    end
  endgenerate

  assign ra = {rd_addr1, rd_addr0};

  // Read resolution, highest priority last: stored -> bypass -> $zero -> reset.
  // we[] is already gated by wr_ena and clear at bit 0, so we[ra] is the bypass hit.
  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd
      always_comb begin
        rd[p] = q[ra[p]];
        if (BYPASS && we[ra[p]])                rd[p] = wr_data;
        if (ra[p] == ADDR_W'(REG_ZERO))         rd[p] = '0;
        if (rst)                                rd[p] = '0;
      end
    end
  endgenerate

  assign rd_data0 = rd[0];
  assign rd_data1 = rd[1];
endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
  import register_file_pkg::*;

  localparam int N = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr0, rd_addr1, wr_addr;
  logic          wr_ena;
  logic [N-1:0]  wr_data;
  logic [N-1:0]  a0, a1, b0, b1;   // a* = BYPASS 0, b* = BYPASS 1

  int ntot = 0;
  int npass = 0;

  always #5 clk = ~clk;

  register_file #(.N(N), .ADDR_W(AW), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(a0), .rd_data1(a1), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data));

  register_file #(.N(N), .ADDR_W(AW), .BYPASS(1'b1)) u_bp (
    .clk(clk), .rst(rst), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(b0), .rd_data1(b1), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data));

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // inputs change 1 time unit after a rising edge; outputs sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [N-1:0] d);
    wr_ena = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_ena = 1'b0;
  endtask

  function automatic logic [N-1:0] walk(input int i);
    return (i == 0) ? '0 : N'((i << 8) | i);
  endfunction

  initial begin
    rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr0 = 5'd1; rd_addr1 = 5'd31;
    #3;
    chk("reset_rd0", a0, '0);
    chk("reset_rd1_bp", b1, '0);
    tick();
    rst = 1'b0;
    #1;

    // basic write/read
    wr(5, 32'hDEADBEEF);
    rd_addr0 = 5'd5; rd_addr1 = 5'd5; #1;
    chk("wr5_rd0", a0, 32'hDEADBEEF);
    chk("wr5_rd1", a1, 32'hDEADBEEF);
    chk("wr5_rd0_bp", b0, 32'hDEADBEEF);
    wr_ena = 1'b0; wr_addr = 5'd5; wr_data = 32'h12345678;
    tick();
    chk("noena_rd0", a0, 32'hDEADBEEF);
    chk("noena_rd1_bp", b1, 32'hDEADBEEF);

    // $zero, including bypass while writing address 0
    wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr1 = 5'd0; #1;
    chk("zero_bypass_rd1", b1, '0);
    chk("zero_nb_rd1", a1, '0);
    tick();
    wr_ena = 1'b0; rd_addr0 = 5'd0; #1;
    chk("zero_rd0", a0, '0);
    chk("zero_rd0_bp", b0, '0);

    // same-cycle read/write on entry 7
    wr(7, 32'h11);
    wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h22; rd_addr0 = 5'd7; rd_addr1 = 5'd5; #1;
    chk("rw7_pre_nb", a0, 32'h11);
    chk("rw7_pre_bp", b0, 32'h22);
    chk("rw7_other_port_bp", b1, 32'hDEADBEEF);
    tick();
    wr_ena = 1'b0; #1;
    chk("rw7_post_nb", a0, 32'h22);
    chk("rw7_post_bp", b0, 32'h22);

    // dual-port independence and swap
    wr(3, 32'hAAAA0000);
    wr(REG_RA, 32'h0000BBBB);
    rd_addr0 = 5'd3; rd_addr1 = 5'(REG_RA); #1;
    chk("dp_rd0", a0, 32'hAAAA0000);
    chk("dp_rd1", a1, 32'h0000BBBB);
    tick();
    rd_addr0 = 5'(REG_RA); rd_addr1 = 5'd3; #1;
    chk("dp_swap_rd0", a0, 32'h0000BBBB);
    chk("dp_swap_rd1", b1, 32'hAAAA0000);

    // walking write over every address, X address while idle
    for (int i = 0; i < 32; i++) wr(i, N'((i << 8) | i));
    wr_addr = 'x; wr_data = 32'hCAFEF00D;
    tick();
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = AW'(i); rd_addr1 = AW'(31 - i); #1;
      chk($sformatf("walk_rd0_%0d", i), a0, walk(i));
      chk($sformatf("walk_rd1_%0d", 31 - i), b1, walk(31 - i));
    end
    chk("walk_sp", a0 == a0 ? walk(REG_SP) : '0, N'((REG_SP << 8) | REG_SP));

    // async reset mid-cycle with bypass write pending
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; rd_addr0 = 5'd9; rd_addr1 = 5'd12;
    rst = 1'b1; #1;
    chk("rst_async_rd0_nb", a0, '0);
    chk("rst_async_rd0_bp", b0, '0);
    chk("rst_async_rd1", a1, '0);
    tick();   // write edge with rst high must be lost
    #2 rst = 1'b0; wr_ena = 1'b0; #1;
    chk("rst_lost_wr9", a0, '0);
    for (int i = 1; i < 32; i++) begin
      rd_addr0 = AW'(i); #1;
      chk($sformatf("rst_clr_%0d", i), a0, '0);
    end

    // first write after release lands at the next edge
    rd_addr0 = 5'd9;
    wr(9, 32'h5A5A5A5A);
    chk("post_rst_wr9", a0, 32'h5A5A5A5A);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- MIPS general-purpose register file: 32 entries of N bits, two read ports and one write port.
- Source side of the A/B operand-capture pair: rd_data0 and rd_data1 feed the datapath operand registers directly.
- Sink of the write-back path: ALU result or memory data arrives via wr_addr, wr_data and wr_ena.
- Entry 0 ($zero) is hardwired to zero.

Parameters:
- N, 32, data width of each entry in bits.
- ADDR_W, 5, address width; entry count = 2**ADDR_W.
- BYPASS, 0, when 1 a same-cycle write is forwarded to the read ports (write-before-read); when 0 reads return the pre-edge contents.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high; clears every entry.
- rd_addr0  input  ADDR_W  read port 0 address (rs).
- rd_addr1  input  ADDR_W  read port 1 address (rt).
- rd_data0  output  N  read port 0 data.
- rd_data1  output  N  read port 1 data.
- wr_ena  input  1  write enable for the current cycle.
- wr_addr  input  ADDR_W  write address (rd/rt after dest mux).
- wr_data  input  N  write data.

Behaviour:
- Storage: 2**ADDR_W entries of N bits, one flop per bit; entry 0 has no storage.
- Reset: rst high clears all entries to 0 immediately, without waiting for clk. While rst is high, rd_data0 = rd_data1 = 0 for any address.
- Write: on a rising clk edge with rst low, wr_ena high and wr_addr != 0, entry[wr_addr] <= wr_data. Otherwise no entry changes.
- Write to address 0 is silently discarded.
- Read: rd_dataK is combinational from rd_addrK, with zero clock latency. An address change is visible in the same cycle.
- rd_addrK == 0 returns 0 regardless of any write.
- BYPASS=0: rd_dataK shows the old entry value until the edge; the new value appears after the edge.
- BYPASS=1: if wr_ena high, wr_addr != 0 and rd_addrK == wr_addr, then rd_dataK = wr_data in that cycle. Otherwise the stored value is returned.
- Both read ports may address the same entry, including the entry being written; each port resolves independently by the rules above.
- Reset released mid-cycle: the first write is taken at the next rising edge with rst low. A write edge coincident with rst high is lost.
- Reset overrides BYPASS: while rst is high, outputs are 0 even when wr_ena is high.
- X on wr_addr with wr_ena low has no effect.
- No handshakes: the datapath controller guarantees wr_ena is only high in write-back states.

Decomposition:
- Shared package/include:
  - REG_ZERO = 0
  - Default N = 32 and ADDR_W = 5
  - Named constants REG_RA = 31 and REG_SP = 29 for bench use.
- Sub-module: write_decoder (ADDR_W to 2**ADDR_W one-hot, gated by wr_ena, bit 0 forced low).
  - Each entry is an instance of the existing N-bit register module.
  - That module's ena is driven by the decoder output and its rst by rst.
- Read muxes are inline: generate over entries, with a priority check for zero and for bypass.

Test Plan:
- Reset: load entries 1..31 with distinct values, assert rst asynchronously between edges -> all reads return 0 before the next edge; after release, reads of 1..31 stay 0.
- Write/read: wr_addr=5, wr_data=0xDEADBEEF, wr_ena=1 for one edge, then rd_addr0=5 and rd_addr1=5 -> both read 0xDEADBEEF; wr_ena=0 with wr_data=0x12345678 for one edge -> entry 5 unchanged.
- $zero: write 0xFFFFFFFF to address 0, then rd_addr0=0 -> reads 0x00000000; rd_addr1=0 with BYPASS=1 while writing address 0 -> reads 0.
- Same-cycle read/write: entry 7 = 0x11, then in one cycle wr_addr=7, wr_data=0x22, rd_addr0=7:
  - BYPASS=0 -> reads 0x11 before the edge and 0x22 after it.
  - BYPASS=1 -> reads 0x22 in the same cycle.
- Dual-port independence: entry 3 = 0xAAAA0000, entry 31 = 0x0000BBBB; rd_addr0=3, rd_addr1=31 -> 0xAAAA0000 and 0x0000BBBB; swap addresses in the next cycle -> outputs swap with no added latency.
- Walking write: write value (i<<8)|i to every address i = 0..31, then read all of them -> address 0 reads 0 and each other address i reads (i<<8)|i, with no aliasing.
